alu_seq_param: RTL and testbench

- Parametrised, registered successor to the combinational PID datapath ALU.
- Takes pre-selected operands and performs add/subtract with x2/x4 prescale and configurable-width saturation in one cycle.
- Performs a signed multiply in a fixed number of cycles using an iterative shift-add engine, with saturation of the product.
- Sits between the PID sequencer and the accumulator/term registers; handshake is start/busy/done.

---
 rtl/alu_seq_param_if.sv | 28 ++
 rtl/alu_seq_param.sv | 191 +++++++++++++++++++
 tb/tb_alu_seq_param.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_param_if.sv
// Handshake and operand bus between the PID sequencer (master) and the
// registered ALU (slave).
interface alu_seq_param_if #(
   parameter int W = 16
);
   logic         start;
   logic [W-1:0] src1;
   logic [W-1:0] src0;
   logic         multiply;
   logic         sub;
   logic         mult2;
   logic         mult4;
   logic         saturate;
   logic [W-1:0] dst;
   logic         done;
   logic         busy;
   logic         sat;

   modport master (
      output start, src1, src0, multiply, sub, mult2, mult4, saturate,
      input  dst, done, busy, sat
   );

   modport slave (
      input  start, src1, src0, multiply, sub, mult2, mult4, saturate,
      output dst, done, busy, sat
   );
endinterface

// File: rtl/alu_seq_param.sv
// Registered PID datapath ALU: single-cycle prescaled add/sub with saturation,
// iterative sign-magnitude shift-add multiply with saturated product.
module alu_seq_param #(
   parameter int W         = 16,
   parameter int SAT_W     = 12,
   parameter int MUL_W     = 15,
   parameter int MUL_SAT_W = 15
) (
   input logic           clk,
   input logic           rst_n,
   alu_seq_param_if.slave bus
);

   localparam int PW = 2 * MUL_W;
   localparam int XW = ((PW > W) ? PW : W) + 1;
   localparam int CW = $clog2(MUL_W + 1);

   localparam logic signed [W:0]    ADD_MAX = {{(W + 2 - SAT_W){1'b0}}, {(SAT_W - 1){1'b1}}};
   localparam logic signed [W:0]    ADD_MIN = {{(W + 2 - SAT_W){1'b1}}, {(SAT_W - 1){1'b0}}};
   localparam logic signed [XW-1:0] MUL_MAX = {{(XW + 1 - MUL_SAT_W){1'b0}}, {(MUL_SAT_W - 1){1'b1}}};
   localparam logic signed [XW-1:0] MUL_MIN = {{(XW + 1 - MUL_SAT_W){1'b1}}, {(MUL_SAT_W - 1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [W-1:0]     p;
   logic [W-1:0]     q;
   logic signed [W:0] sum;
   logic [W-1:0]     add_res;
   logic             add_sat;

   logic [MUL_W-1:0] a_op;
   logic [MUL_W-1:0] b_op;
   logic [MUL_W-1:0] a_mag;
   logic [MUL_W-1:0] b_mag;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    acc_nxt;
   logic [PW-1:0]    mcand;
   logic [MUL_W-1:0] mplier;
   logic             neg;
   logic [CW-1:0]    cnt;
   logic [PW-1:0]    prod;
   logic signed [XW-1:0] prod_x;
   logic [W-1:0]     mul_res;
   logic             mul_sat;

   logic [W-1:0]     dst_r;
   logic             sat_r;
   logic             done_r;
   logic             add_go;
   logic             mul_go;
   logic             mul_last;

   // src0 prescale then optional two's-complement negation, all in W bits
   always_comb begin
      p = bus.src0;
      if (bus.mult4) begin
         p = bus.src0 << 2;
      end else if (bus.mult2) begin
         p = bus.src0 << 1;
      end
      q = bus.sub ? -p : p;
   end

   assign sum = $signed({bus.src1[W-1], bus.src1}) + $signed({q[W-1], q});

   always_comb begin
      add_res = sum[W-1:0];
      add_sat = 1'b0;
      if (bus.saturate) begin
         if (sum > ADD_MAX) begin
            add_res = ADD_MAX[W-1:0];
            add_sat = 1'b1;
         end else if (sum < ADD_MIN) begin
            add_res = ADD_MIN[W-1:0];
            add_sat = 1'b1;
         end
      end
   end

   // Magnitudes fit MUL_W unsigned bits even for the most-negative operand
   assign a_op  = bus.src1[MUL_W-1:0];
   assign b_op  = q[MUL_W-1:0];
   assign a_mag = a_op[MUL_W-1] ? -a_op : a_op;
   assign b_mag = b_op[MUL_W-1] ? -b_op : b_op;

   assign acc_nxt = acc + (mplier[0] ? mcand : '0);
   assign prod    = neg ? -acc_nxt : acc_nxt;
   assign prod_x  = $signed({{(XW - PW){prod[PW-1]}}, prod});

   always_comb begin
      mul_res = prod_x[W-1:0];
      mul_sat = 1'b0;
      if (prod_x > MUL_MAX) begin
         mul_res = MUL_MAX[W-1:0];
         mul_sat = 1'b1;
      end else if (prod_x < MUL_MIN) begin
         mul_res = MUL_MIN[W-1:0];
         mul_sat = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      add_go    = 1'b0;
      mul_go    = 1'b0;
      mul_last  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.multiply) begin
                  mul_go    = 1'b1;
                  state_nxt = MUL;
               end else begin
                  add_go = 1'b1;
               end
            end
         end
         MUL: begin
            if (cnt == CW'(1)) begin
               mul_last  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Product is finalised on the last step edge so dst/sat are valid in DONE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dst_r  <= '0;
         sat_r  <= 1'b0;
         done_r <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         cnt    <= '0;
      end else begin
         done_r <= 1'b0;
         if (add_go) begin
            dst_r  <= add_res;
            sat_r  <= add_sat;
            done_r <= 1'b1;
         end
         if (mul_go) begin
            acc    <= '0;
            mcand  <= {{MUL_W{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= a_op[MUL_W-1] ^ b_op[MUL_W-1];
            cnt    <= CW'(MUL_W);
         end
         if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
         end
         if (mul_last) begin
            dst_r  <= mul_res;
            sat_r  <= mul_sat;
            done_r <= 1'b1;
         end
      end
   end

   assign bus.dst  = dst_r;
   assign bus.sat  = sat_r;
   assign bus.done = done_r;
   assign bus.busy = (state == MUL);

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed plus randomised checks of alu_seq_param using an expected-result
// queue drained whenever done pulses.
module tb_alu_seq_param;
   localparam int W     = 16;
   localparam int MUL_W = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   alu_seq_param_if #(.W(W)) bus ();

   alu_seq_param #(
      .W        (W),
      .SAT_W    (12),
      .MUL_W    (MUL_W),
      .MUL_SAT_W(15)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [W-1:0] exp_dst_q[$];
   logic         exp_sat_q[$];
   int passes = 0;
   int total  = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [W-1:0] s1, input logic [W-1:0] s0,
                                 input bit mul, input bit sb, input bit m2, input bit m4,
                                 input bit st, output logic [W-1:0] d, output logic s);
      logic [W-1:0] pv, qv;
      logic signed [MUL_W-1:0] a, b;
      longint r, lo, hi;
      pv = m4 ? {s0[13:0], 2'b00} : (m2 ? {s0[14:0], 1'b0} : s0);
      qv = sb ? (~pv + 16'd1) : pv;
      if (mul) begin
         a  = s1[MUL_W-1:0];
         b  = qv[MUL_W-1:0];
         r  = longint'(a) * longint'(b);
         lo = -16384;
         hi = 16383;
      end else begin
         r  = longint'($signed(s1)) + longint'($signed(qv));
         lo = -2048;
         hi = 2047;
      end
      s = 1'b0;
      if (mul || st) begin
         if (r > hi) begin
            r = hi;
            s = 1'b1;
         end else if (r < lo) begin
            r = lo;
            s = 1'b1;
         end
      end
      d = r[W-1:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [W-1:0] s1, input logic [W-1:0] s0, input bit mul,
                        input bit sb, input bit m2, input bit m4, input bit st);
      bus.src1     = s1;
      bus.src0     = s0;
      bus.multiply = mul;
      bus.sub      = sb;
      bus.mult2    = m2;
      bus.mult4    = m4;
      bus.saturate = st;
      bus.start    = 1'b1;
   endtask

   task automatic push(input logic [W-1:0] d, input logic s);
      exp_dst_q.push_back(d);
      exp_sat_q.push_back(s);
   endtask

   // Add that must complete on the very next cycle
   task automatic add_op(input logic [W-1:0] s1, input logic [W-1:0] s0, input bit sb,
                         input bit m2, input bit m4, input bit st,
                         input logic [W-1:0] ed, input logic es);
      issue(s1, s0, 1'b0, sb, m2, m4, st);
      push(ed, es);
      step();
      bus.start = 1'b0;
      chk("add_done_latency", bus.done, 1);
   endtask

   task automatic mul_run(input logic [W-1:0] s1, input logic [W-1:0] s0, input bit sb,
                          input logic [W-1:0] ed, input logic es,
                          input bit poke5, input bit poke_done);
      issue(s1, s0, 1'b1, sb, 1'b0, 1'b0, 1'b0);
      push(ed, es);
      step();
      bus.start = 1'b0;
      for (int k = 1; k <= MUL_W; k++) begin
         chk($sformatf("mul_busy_c%0d", k), bus.busy, 1);
         chk($sformatf("mul_nodone_c%0d", k), bus.done, 0);
         if (poke5 && k == 5) issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         step();
         bus.start = 1'b0;
      end
      chk("mul_busy_done_cycle", bus.busy, 0);
      chk("mul_done_pulse", bus.done, 1);
      if (poke_done) issue(16'h0010, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      bus.start = 1'b0;
      chk("mul_done_single", bus.done, 0);
      chk("mul_idle_busy", bus.busy, 0);
   endtask

   always @(negedge clk) begin
      logic [W-1:0] d;
      logic         s;
      if (rst_n && bus.done === 1'b1) begin
         if (exp_dst_q.size() == 0) begin
            total++;
            fails++;
            $error("FAIL unexpected_done observed=dst 0x%0h expected=no done", bus.dst);
         end else begin
            d = exp_dst_q.pop_front();
            s = exp_sat_q.pop_front();
            chk("sb_dst", bus.dst, d);
            chk("sb_sat", bus.sat, s);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] s1, s0, ed;
      logic         es;
      bit           sb, m2, m4, st;

      bus.start = 1'b0;
      issue(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.start = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      chk("rst_dst", bus.dst, 16'h0000);
      chk("rst_done", bus.done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_sat", bus.sat, 0);
      rst_n = 1'b1;
      step();

      // Back-to-back adds on consecutive cycles
      issue(16'h0100, 16'h0023, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      push(16'h0123, 1'b0);
      step();
      chk("add1_done", bus.done, 1);
      issue(16'h0010, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      push(16'h0020, 1'b0);
      step();
      bus.start = 1'b0;
      chk("add2_done", bus.done, 1);
      step();
      chk("add_idle_done", bus.done, 0);

      add_op(16'hF900, 16'h0400, 1'b1, 1'b0, 1'b0, 1'b1, 16'hF800, 1'b1);
      add_op(16'hF900, 16'h0400, 1'b1, 1'b0, 1'b0, 1'b0, 16'hF500, 1'b0);
      add_op(16'h0600, 16'h0100, 1'b0, 1'b1, 1'b1, 1'b1, 16'h07FF, 1'b1);
      add_op(16'h0600, 16'h0100, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0A00, 1'b0);
      add_op(16'h07FF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h07FF, 1'b0);
      step();

      mul_run(16'h0064, 16'hFFCE, 1'b0, 16'hEC78, 1'b0, 1'b0, 1'b0);
      mul_run(16'h0200, 16'h0100, 1'b0, 16'h3FFF, 1'b1, 1'b0, 1'b0);
      mul_run(16'h0200, 16'hFF00, 1'b0, 16'hC000, 1'b1, 1'b0, 1'b0);
      mul_run(16'h4000, 16'h4000, 1'b0, 16'h3FFF, 1'b1, 1'b0, 1'b0);
      // start pulses mid-multiply and in DONE must be ignored
      mul_run(16'h0064, 16'h0032, 1'b1, 16'hEC78, 1'b0, 1'b1, 1'b1);
      chk("ignored_start_nodone", bus.done, 0);
      step();

      // Reset in cycle 8 of a multiply aborts it without done
      issue(16'h0064, 16'hFFCE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      bus.start = 1'b0;
      for (int k = 1; k < 8; k++) step();
      chk("pre_rst_busy", bus.busy, 1);
      rst_n = 1'b0;
      step();
      chk("midrst_dst", bus.dst, 16'h0000);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      chk("midrst_sat", bus.sat, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("postrst_nodone", bus.done, 0);
      end
      add_op(16'h0100, 16'h0023, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0123, 1'b0);
      step();

      for (int i = 0; i < 12; i++) begin
         s1 = 16'($urandom);
         s0 = 16'($urandom);
         sb = 1'($urandom);
         m2 = 1'($urandom);
         m4 = 1'($urandom);
         st = 1'($urandom);
         model(s1, s0, 1'b0, sb, m2, m4, st, ed, es);
         add_op(s1, s0, sb, m2, m4, st, ed, es);
      end
      step();
      for (int i = 0; i < 4; i++) begin
         s1 = 16'($urandom);
         s0 = (i < 2) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         sb = 1'($urandom);
         model(s1, s0, 1'b1, sb, 1'b0, 1'b0, 1'b0, ed, es);
         mul_run(s1, s0, sb, ed, es, 1'b0, 1'b0);
      end

      step();
      step();
      chk("queue_drained", 16'(exp_dst_q.size()), 16'h0000);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
